// File: rtl/ipa_ctx_distrib.sv
// ipa_ctx_distrib
//
// Purpose: accepts context words streamed from the DMA, decodes the one-hot
// tile mask into a binary tile index, buffers the decoded entries in a small
// FIFO and replays them to the tile array one write at a time. After the
// Exec_En_i pulse marks the end of loading, the block waits for the buffer to
// drain and then issues a single exec_start_o pulse.
//
// Optional feature macro: IPA_CTX_MASK_CHK_EN
//   defined   : words with a zero mask, more than one mask bit set, or a mask
//               bit at or above NB_TILES are dropped and err_o becomes sticky.
//   undefined : every word is pushed, the lowest set mask bit is encoded
//               (all-zero mask -> index 0) and err_o is tied to 0.
//
// Ports:
//   Clk             in   single clock, rising edge
//   Reset           in   asynchronous, active-high reset
//   Write_En_i      in   context word valid (no backpressure)
//   Data_i[63:0]    in   context word
//   Addr_i[22:0]    in   [15:0] one-hot tile mask, [16] 1=constant,
//                        [22:17] local slot
//   Exec_En_i       in   load complete, start execution (one-cycle pulse)
//   tile_gnt_i      in   tile accepts the current write
//   tile_wr_o       out  tile write request
//   tile_sel_o      out  binary tile index
//   tile_is_const_o out  constant-memory write
//   tile_addr_o     out  local slot (constants use [3:0])
//   tile_data_o     out  write data
//   exec_start_o    out  one-cycle execution launch pulse
//   busy_o          out  buffer non-empty or launch still pending
//   ovf_o           out  sticky: word dropped because the buffer was full
//   err_o           out  sticky: word dropped because of a bad mask
//   dbg_state_o     out  current FSM state (0 IDLE, 1 LOAD, 2 DRAIN, 3 LAUNCH)
//
// Tile handshake: tile_wr_o is a valid that depends only on registered state.
// Once raised, tile_wr_o and the head entry on tile_sel_o/tile_is_const_o/
// tile_addr_o/tile_data_o stay stable until a cycle in which tile_gnt_i is
// also high; that cycle is the transfer and the next entry (if any) appears
// on the following cycle.

module ipa_ctx_distrib #(
  parameter int FIFO_DEPTH = 4,
  parameter int NB_TILES   = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Write_En_i,
  input  logic [63:0] Data_i,
  input  logic [22:0] Addr_i,
  input  logic        Exec_En_i,
  input  logic        tile_gnt_i,
  output logic        tile_wr_o,
  output logic [3:0]  tile_sel_o,
  output logic        tile_is_const_o,
  output logic [5:0]  tile_addr_o,
  output logic [63:0] tile_data_o,
  output logic        exec_start_o,
  output logic        busy_o,
  output logic        ovf_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_LAUNCH = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]  sel;
    logic        is_const;
    logic [5:0]  slot;
    logic [63:0] data;
  } entry_t;

  // ---------------------------------------------------------------------
  // Mask decode
  // ---------------------------------------------------------------------
  logic [15:0] mask;
  logic [3:0]  mask_idx;
  logic [15:0] legal_mask;
  logic        mask_ok;
  entry_t      new_entry;

  assign mask = Addr_i[15:0];

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    mask_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) mask_idx = i[3:0];
    end
  end

  always_comb begin
    legal_mask = '0;
    for (int i = 0; i < 16; i++) begin
      legal_mask[i] = (i < NB_TILES);
    end
  end

`ifdef IPA_CTX_MASK_CHK_EN
  logic mask_single;
  assign mask_single = (mask != 16'd0) && ((mask & (mask - 16'd1)) == 16'd0);
  assign mask_ok     = mask_single && ((mask & ~legal_mask) == 16'd0);
`else
  logic legal_unused;
  assign legal_unused = ^legal_mask;
  assign mask_ok      = 1'b1;
`endif

  // Constant memory is only 16 deep, so the upper slot bits are cleared.
  always_comb begin
    new_entry.sel      = mask_idx;
    new_entry.is_const = Addr_i[16];
    new_entry.slot     = Addr_i[16] ? {2'b00, Addr_i[20:17]} : Addr_i[22:17];
    new_entry.data     = Data_i;
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q;
  logic          empty, full, push, pop;
  entry_t        head;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = !empty && tile_gnt_i;
  // A full buffer still takes a word when the head leaves in the same cycle.
  assign push  = Write_En_i && mask_ok && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (Write_En_i && mask_ok && !push) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: it is only observed while count_q says it is valid.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

`ifdef IPA_CTX_MASK_CHK_EN
  logic err_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) err_q <= 1'b0;
    else if (Write_En_i && !mask_ok) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Launch sequencing
  // ---------------------------------------------------------------------
  state_e state_q;
  logic   exec_start_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      exec_start_q <= 1'b0;
    end else begin
      exec_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Exec_En_i) begin
            // Nothing to deliver: launch straight away.
            if (empty && !push) begin
              state_q      <= ST_LAUNCH;
              exec_start_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (push) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (Exec_En_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Late pushes keep the block here until they have been delivered.
          if (empty && !push) begin
            state_q      <= ST_LAUNCH;
            exec_start_q <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign head            = mem_q[rd_ptr_q];
  assign tile_wr_o       = !empty;
  assign tile_sel_o      = empty ? 4'd0  : head.sel;
  assign tile_is_const_o = empty ? 1'b0  : head.is_const;
  assign tile_addr_o     = empty ? 6'd0  : head.slot;
  assign tile_data_o     = empty ? 64'd0 : head.data;
  assign exec_start_o    = exec_start_q;
  assign busy_o          = (state_q != ST_IDLE) || !empty;
  assign ovf_o           = ovf_q;
  assign dbg_state_o     = state_q;

endmodule
